// File: rtl/systolic_result_drain.sv
// Snapshots a finished systolic array result matrix and streams it out row-major,
// LANES elements per valid/ready beat, with optional saturation to OUT_WIDTH.
module systolic_result_drain #(
    parameter int ROWS      = 64,
    parameter int COLS      = 64,
    parameter int OP_WIDTH  = 48,
    parameter int OUT_WIDTH = 32,
    parameter int LANES     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          compute_done,
    input  logic [ROWS*COLS*OP_WIDTH-1:0] result_matrix,
    input  logic                          sat_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*OUT_WIDTH-1:0]    out_data,
    output logic [31:0]                   out_row,
    output logic [31:0]                   out_col,
    output logic                          out_last,
    output logic                          busy,
    output logic                          frame_done,
    output logic [31:0]                   sat_count,
    output logic                          missed_frame
);

    localparam int NBEATS = ROWS * COLS / LANES;
    localparam int BPR    = COLS / LANES;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic signed [OP_WIDTH-1:0] MAXV =
        {{(OP_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [OP_WIDTH-1:0] MINV = ~MAXV;
    localparam logic [OUT_WIDTH-1:0] MAX_OUT = MAXV[OUT_WIDTH-1:0];
    localparam logic [OUT_WIDTH-1:0] MIN_OUT = MINV[OUT_WIDTH-1:0];

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                          state;
    state_t                          state_next;
    logic                            done_q;
    logic [BEAT_W-1:0]               beat;
    logic [ROWS*COLS*OP_WIDTH-1:0]   snap;
    logic                            start;
    logic                            handshake;
    logic                            last_beat;
    logic [31:0]                     base_elem;
    logic [31:0]                     clamp_cnt;
    logic signed [OP_WIDTH-1:0]      lane_val [LANES];

    assign start     = compute_done & ~done_q;
    assign handshake = (state == STREAM) & out_ready;
    assign last_beat = (beat == BEAT_W'(NBEATS - 1));
    assign base_elem = 32'(beat) * 32'(LANES);

    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_last  = (state == STREAM) & last_beat;
    assign out_row   = 32'(beat) / 32'(BPR);
    assign out_col   = (32'(beat) % 32'(BPR)) * 32'(LANES);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = STREAM;
            STREAM: if (handshake && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Lane formatting: clamp counting is always evaluated, but only accumulated when sat_en is set.
    always_comb begin
        out_data  = '0;
        clamp_cnt = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_val[k] = snap[(base_elem + 32'(k)) * OP_WIDTH +: OP_WIDTH];
            if (lane_val[k] > MAXV) begin
                clamp_cnt = clamp_cnt + 32'd1;
                out_data[k*OUT_WIDTH +: OUT_WIDTH] = sat_en ? MAX_OUT : lane_val[k][OUT_WIDTH-1:0];
            end else if (lane_val[k] < MINV) begin
                clamp_cnt = clamp_cnt + 32'd1;
                out_data[k*OUT_WIDTH +: OUT_WIDTH] = sat_en ? MIN_OUT : lane_val[k][OUT_WIDTH-1:0];
            end else begin
                out_data[k*OUT_WIDTH +: OUT_WIDTH] = lane_val[k][OUT_WIDTH-1:0];
            end
        end
        if (state != STREAM) out_data = '0;
    end

    // Snapshot is deliberately unreset; it is only observed while streaming.
    always_ff @(posedge clk) begin
        if (state == IDLE && start && !rst) snap <= result_matrix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q       <= 1'b0;
            beat         <= '0;
            sat_count    <= '0;
            missed_frame <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            done_q     <= compute_done;
            frame_done <= handshake & last_beat;
            if (state == IDLE) begin
                if (start) begin
                    beat      <= '0;
                    sat_count <= '0;
                end
            end else begin
                if (start) missed_frame <= 1'b1;
                if (handshake) begin
                    if (sat_en) sat_count <= sat_count + clamp_cnt;
                    if (!last_beat) beat <= beat + BEAT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain (4x4 array, 2 lanes, 48->16 bit).
module tb_systolic_result_drain;

    localparam int ROWS = 4, COLS = 4, OPW = 48, OUTW = 16, LANES = 2;
    localparam int NB = ROWS * COLS / LANES;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       compute_done;
    logic [ROWS*COLS*OPW-1:0]   result_matrix;
    logic                       sat_en;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*OUTW-1:0]      out_data;
    logic [31:0]                out_row;
    logic [31:0]                out_col;
    logic                       out_last;
    logic                       busy;
    logic                       frame_done;
    logic [31:0]                sat_count;
    logic                       missed_frame;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] data;
        int          row;
        int          col;
        bit          last;
    } beat_t;

    typedef struct {
        longint      v0;
        longint      v1;
        bit          sat;
        logic [15:0] e0;
        logic [15:0] e1;
        int          ecnt;
    } vec_t;

    beat_t sb[$];

    systolic_result_drain #(
        .ROWS(ROWS), .COLS(COLS), .OP_WIDTH(OPW), .OUT_WIDTH(OUTW), .LANES(LANES)
    ) dut (
        .clk(clk), .rst(rst), .compute_done(compute_done), .result_matrix(result_matrix),
        .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy),
        .frame_done(frame_done), .sat_count(sat_count), .missed_frame(missed_frame)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads the matrix (element e = e, with elements 0/1 overridden) and queues the expected frame.
    task automatic applyStimulus(input vec_t v);
        beat_t b;
        for (int e = 0; e < ROWS*COLS; e++) result_matrix[e*OPW +: OPW] = 48'(e);
        result_matrix[0 +: OPW]   = 48'(v.v0);
        result_matrix[OPW +: OPW] = 48'(v.v1);
        sat_en = v.sat;
        sb.delete();
        for (int i = 0; i < NB; i++) begin
            b.data = (i == 0) ? {v.e1, v.e0} : {16'(2*i + 1), 16'(2*i)};
            b.row  = i / 2;
            b.col  = (i % 2) * 2;
            b.last = (i == NB - 1);
            sb.push_back(b);
        end
    endtask

    task automatic startFrame();
        compute_done = 1'b1;
        tick();
        checkOutput("first_beat_valid", 64'(out_valid), 64'd1);
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1. pulse_at re-triggers compute_done
    // and scrambles the input matrix; abort_at asserts rst and returns immediately.
    task automatic drainFrame(input int mode, input int pulse_at, input int abort_at,
                              output int cycles, output int hs);
        cycles = 0;
        hs = 0;
        while (hs < NB && cycles < 100) begin
            if (cycles == abort_at) begin
                rst = 1'b1;
                return;
            end
            if (cycles == pulse_at) begin
                compute_done  = 1'b0;
                result_matrix = {(ROWS*COLS*OPW/16){16'hA5A5}};
            end
            if (cycles == pulse_at + 1) compute_done = 1'b1;
            out_ready = (mode == 0) ? 1'b1 : ((cycles % 4 == 0) || (cycles % 4 == 3));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", 64'(out_valid), 64'd0);
                end else begin
                    checkOutput("beat_data", 64'(out_data), 64'(sb[0].data));
                    checkOutput("beat_row",  64'(out_row),  64'(sb[0].row));
                    checkOutput("beat_col",  64'(out_col),  64'(sb[0].col));
                    checkOutput("beat_last", 64'(out_last), 64'(sb[0].last));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        hs++;
                    end
                end
            end
            tick();
            cycles++;
        end
        out_ready = 1'b0;
        checkOutput("drain_handshakes", 64'(hs), 64'(NB));
    endtask

    task automatic checkFrameEnd();
        checkOutput("frame_done_pulse", 64'(frame_done), 64'd1);
        checkOutput("valid_after_frame", 64'(out_valid), 64'd0);
        tick();
        checkOutput("frame_done_single", 64'(frame_done), 64'd0);
    endtask

    vec_t vecs[8];
    int   cyc;
    int   hs;
    int   vcount;

    initial begin
        vecs[0] = '{0,       1,      1'b1, 16'h0000, 16'h0001, 0};
        vecs[1] = '{40000,   -40000, 1'b1, 16'h7FFF, 16'h8000, 2};
        vecs[2] = '{40000,   -40000, 1'b0, 16'h9C40, 16'h63C0, 0};
        vecs[3] = '{32767,   -32768, 1'b1, 16'h7FFF, 16'h8000, 0};
        vecs[4] = '{32768,   -32769, 1'b1, 16'h7FFF, 16'h8000, 2};
        vecs[5] = '{-1,      5,      1'b1, 16'hFFFF, 16'h0005, 0};
        vecs[6] = '{74565,   -65537, 1'b0, 16'h2345, 16'hFFFF, 0};
        vecs[7] = '{74565,   -65537, 1'b1, 16'h7FFF, 16'h8000, 2};

        rst = 1'b1;
        compute_done = 1'b0;
        out_ready = 1'b1;
        sat_en = 1'b0;
        result_matrix = '0;
        tick();
        tick();
        checkOutput("rst_valid",    64'(out_valid),    64'd0);
        checkOutput("rst_busy",     64'(busy),         64'd0);
        checkOutput("rst_last",     64'(out_last),     64'd0);
        checkOutput("rst_done",     64'(frame_done),   64'd0);
        checkOutput("rst_satcnt",   64'(sat_count),    64'd0);
        checkOutput("rst_missed",   64'(missed_frame), 64'd0);
        checkOutput("rst_row",      64'(out_row),      64'd0);
        checkOutput("rst_col",      64'(out_col),      64'd0);
        checkOutput("rst_data",     64'(out_data),     64'd0);
        rst = 1'b0;
        tick();
        checkOutput("idle_ready_no_effect", 64'(out_valid), 64'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            startFrame();
            drainFrame(i % 2, -10, -1, cyc, hs);
            if (i % 2 == 0) checkOutput("back_to_back_cycles", 64'(cyc), 64'(NB));
            checkFrameEnd();
            checkOutput("sat_count", 64'(sat_count), 64'(vecs[i].ecnt));
            checkOutput("no_missed", 64'(missed_frame), 64'd0);
            compute_done = 1'b0;
            tick();
        end

        // Retrigger mid-frame: stream keeps the original snapshot, miss is flagged.
        applyStimulus(vecs[0]);
        startFrame();
        drainFrame(0, 3, -1, cyc, hs);
        checkFrameEnd();
        checkOutput("missed_sticky", 64'(missed_frame), 64'd1);
        checkOutput("no_retrigger", 64'(out_valid), 64'd0);

        // Reset at beat 5 with compute_done held high: abort, then restart on first edge after release.
        compute_done = 1'b0;
        tick();
        applyStimulus(vecs[1]);
        startFrame();
        drainFrame(0, -10, 5, cyc, hs);
        tick();
        checkOutput("abort_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_no_done", 64'(frame_done), 64'd0);
        checkOutput("abort_missed_clr", 64'(missed_frame), 64'd0);
        rst = 1'b0;
        applyStimulus(vecs[1]);
        tick();
        checkOutput("restart_valid", 64'(out_valid), 64'd1);
        drainFrame(0, -10, -1, cyc, hs);
        checkFrameEnd();
        checkOutput("restart_satcnt", 64'(sat_count), 64'd2);

        // compute_done still high: no further frames over 30 cycles.
        vcount = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) vcount++;
            tick();
        end
        checkOutput("held_high_one_frame", 64'(vcount), 64'd0);
        checkOutput("satcnt_holds_idle", 64'(sat_count), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 Parameter ROWS, default 64, array row count.
REQ-002 Parameter COLS, default 64, array column count.
REQ-003 Parameter OP_WIDTH, default 48, signed accumulator width per element.
REQ-004 Parameter OUT_WIDTH, default 32, signed streamed element width; SHALL satisfy OUT_WIDTH <= OP_WIDTH.
REQ-005 Parameter LANES, default 4, elements per beat; COLS SHALL be divisible by LANES.
REQ-006 clk  in  1  clock; all logic rising-edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 compute_done  in  1  level from array; rising edge marks results valid.
REQ-009 result_matrix  in  ROWS*COLS*OP_WIDTH  flat results; element (i,j) at bits [(i*COLS+j)*OP_WIDTH +: OP_WIDTH].
REQ-010 sat_en  in  1  1 = saturate to OUT_WIDTH, 0 = truncate to low OUT_WIDTH bits.
REQ-011 out_valid  out  1  beat available.
REQ-012 out_ready  in  1  downstream accepts beat.
REQ-013 out_data  out  LANES*OUT_WIDTH  lane k at bits [k*OUT_WIDTH +: OUT_WIDTH].
REQ-014 out_row  out  32  row index i of current beat.
REQ-015 out_col  out  32  column of lane 0 of current beat.
REQ-016 out_last  out  1  high on final beat of frame.
REQ-017 busy  out  1  high while in STREAM.
REQ-018 frame_done  out  1  one-cycle pulse after final beat accepted.
REQ-019 sat_count  out  32  elements clamped in current/last frame.
REQ-020 missed_frame  out  1  sticky: a frame arrived while busy.

Function
REQ-021 States SHALL be IDLE and STREAM only.
REQ-022 Block SHALL register compute_done (done_q); start event = compute_done & ~done_q.
REQ-023 On start event in IDLE: snapshot all of result_matrix into internal storage at that edge, clear beat counter, clear sat_count, enter STREAM.
REQ-024 out_valid SHALL be high exactly when state is STREAM; first beat valid in cycle after start edge.
REQ-025 Beats SHALL be row-major: beat b covers row b/(COLS/LANES), columns (b mod (COLS/LANES))*LANES .. +LANES-1.
REQ-026 Beat advances only on out_valid & out_ready at clock edge; while out_valid & ~out_ready, out_data/out_row/out_col/out_last SHALL hold stable.
REQ-027 Total beats per frame SHALL be ROWS*COLS/LANES; out_last high only on beat ROWS*COLS/LANES-1.
REQ-028 On handshake of last beat: return to IDLE, assert frame_done for exactly the next cycle.
REQ-029 Saturation: with sat_en=1, value > 2^(OUT_WIDTH-1)-1 outputs max, value < -2^(OUT_WIDTH-1) outputs min; otherwise sign-preserved low bits.
REQ-030 With sat_en=0, output SHALL be low OUT_WIDTH bits, no clamping.
REQ-031 sat_count SHALL increment by number of clamped lanes on each accepted beat (sat_en=1 only); holds in IDLE.
REQ-032 sat_en SHALL be sampled per beat at handshake time for counting and continuously for out_data.
REQ-033 Start event while STREAM: ignored, snapshot unchanged, missed_frame set to 1.
REQ-034 compute_done held high across frames SHALL NOT retrigger; new frame requires low-then-high.
REQ-035 Snapshot storage SHALL be independent of result_matrix after capture; input changes during STREAM SHALL NOT affect out_data.
REQ-036 out_ready may be high while out_valid low; no effect.

Reset
REQ-037 On rst: state IDLE, out_valid 0, out_last 0, busy 0, frame_done 0, sat_count 0, missed_frame 0, done_q 0, out_row 0, out_col 0, out_data 0.
REQ-038 rst mid-STREAM SHALL abort frame immediately, no frame_done pulse; a compute_done already high at release SHALL start a frame only after done_q observes it low-to-high... i.e. done_q resets to 0, so a high compute_done causes a start on the first post-reset edge.
REQ-039 Snapshot storage need not be reset.

Verification (ROWS=COLS=4, LANES=2, OP_WIDTH=48, OUT_WIDTH=16)
REQ-040 Element (i,j)=i*4+j, out_ready=1 -> 8 beats in 8 consecutive cycles, beat0 lanes {0,1}, beat7 {14,15} with out_last, frame_done next cycle.
REQ-041 out_ready toggling 1,0,0,1 repeating -> each beat held stable while stalled, order unchanged, 8 handshakes total.
REQ-042 Element (0,0)=40000, (0,1)=-40000, sat_en=1 -> lanes 32767, -32768, sat_count=2; sat_en=0 -> 0x9C40, 0x63C0, sat_count=0.
REQ-043 Second compute_done rising edge at beat 3 -> stream continues with original data, missed_frame=1 after frame.
REQ-044 rst at beat 5 -> out_valid 0 next cycle, no frame_done; new rising edge -> full 8-beat frame from beat 0.
REQ-045 compute_done held high 30 cycles -> exactly one frame.
